// File: rtl/pcileech_msix_pkg.sv
// pcileech_msix_pkg: shared types and constants for the MSI-X message block.
// FSM states, table DWORD offsets and the vector-control mask bit position.
package pcileech_msix_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EVAL,
    SEND
  } msix_state_e;

  localparam logic [1:0] MSIX_DW_ADDR_LO = 2'd0;
  localparam logic [1:0] MSIX_DW_ADDR_HI = 2'd1;
  localparam logic [1:0] MSIX_DW_DATA    = 2'd2;
  localparam logic [1:0] MSIX_DW_VCTRL   = 2'd3;

  localparam int MSIX_VCTRL_MASK_BIT = 0;

endpackage

// File: rtl/pcileech_msix_rr_arb.sv
// pcileech_msix_rr_arb: combinational round-robin first-set-bit finder.
// Ports: pba (pending bits), ptr (start index) -> found, index.
module pcileech_msix_rr_arb #(
  parameter int NUM_VEC = 8,
  parameter int IW      = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
  input  logic [NUM_VEC-1:0] pba,
  input  logic [IW-1:0]      ptr,
  output logic               found,
  output logic [IW-1:0]      index
);

  logic [IW-1:0] cand;

  // NUM_VEC is a power of two, so IW-bit addition wraps modulo NUM_VEC.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int i = 0; i < NUM_VEC; i++) begin
      cand = ptr + IW'(i);
      if (!found && pba[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/pcileech_msix_msg.sv
// pcileech_msix_msg: latches per-vector requests, fetches the MSI-X table
// entry and emits address/data descriptors on a valid/ready interface.
// Ports: clk, rst_n, msix_enable, func_mask, vec_req -> pba;
//   tbl_rden/tbl_rd_addr/tbl_rd_data table port; tx_valid/tx_ready/
//   tx_addr/tx_data descriptor port; addr_err drop pulse.
// Option: PCILEECH_MSIX_HOLDOFF_EN enforces HOLDOFF cycles between messages.
module pcileech_msix_msg #(
  parameter int NUM_VEC = 8,
  parameter int TBL_LAT = 2,
  parameter int HOLDOFF = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       msix_enable,
  input  logic                       func_mask,
  input  logic [NUM_VEC-1:0]         vec_req,
  output logic                       tbl_rden,
  output logic [$clog2(NUM_VEC)+1:0] tbl_rd_addr,
  input  logic [31:0]                tbl_rd_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [63:0]                tx_addr,
  output logic [31:0]                tx_data,
  output logic [NUM_VEC-1:0]         pba,
  output logic                       addr_err
);
  import pcileech_msix_pkg::*;

  localparam int IW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
  localparam int AW = $clog2(NUM_VEC) + 2;

  msix_state_e state, state_n;

  logic [IW-1:0]      sel, ptr, arb_idx;
  logic               arb_found;
  logic [2:0]         iss;
  logic [1:0]         cap;
  logic [TBL_LAT-1:0] rd_pipe;
  logic [31:0]        addr_lo, addr_hi, msg_data;
  logic               vmask;
  logic               go, drop, hs, adv, cap_en, hold_ok;
  logic [NUM_VEC-1:0] clr;
  logic [IW+1:0]      rd_full;

  pcileech_msix_rr_arb #(
    .NUM_VEC(NUM_VEC),
    .IW     (IW)
  ) u_arb (
    .pba  (pba),
    .ptr  (ptr),
    .found(arb_found),
    .index(arb_idx)
  );

  assign tx_addr     = {addr_hi, addr_lo};
  assign tx_data     = msg_data;
  assign cap_en      = rd_pipe[TBL_LAT-1];
  assign rd_full     = {sel, iss[1:0]};
  assign tbl_rd_addr = rd_full[AW-1:0];

  always_comb begin
    state_n  = state;
    tbl_rden = 1'b0;
    tx_valid = 1'b0;
    addr_err = 1'b0;
    go       = 1'b0;
    drop     = 1'b0;
    hs       = 1'b0;
    adv      = 1'b0;
    unique case (state)
      IDLE: begin
        if (msix_enable && !func_mask && arb_found && hold_ok) begin
          go      = 1'b1;
          state_n = FETCH;
        end
      end
      FETCH: begin
        tbl_rden = !iss[2];
        if (cap_en && cap == MSIX_DW_VCTRL) state_n = EVAL;
      end
      EVAL: begin
        state_n = IDLE;
        if (msix_enable && !func_mask) begin
          if (vmask) begin
            adv = 1'b1;
          end else if (addr_lo[1:0] != 2'b00) begin
            drop     = 1'b1;
            adv      = 1'b1;
            addr_err = 1'b1;
          end else begin
            state_n = SEND;
          end
        end
      end
      SEND: begin
        // once raised, valid holds until the handshake regardless of masks
        tx_valid = 1'b1;
        if (tx_ready) begin
          hs      = 1'b1;
          adv     = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    clr = '0;
    if (drop || hs) clr = NUM_VEC'(1) << sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pba      <= '0;
      sel      <= '0;
      ptr      <= '0;
      iss      <= '0;
      cap      <= '0;
      rd_pipe  <= '0;
      addr_lo  <= '0;
      addr_hi  <= '0;
      msg_data <= '0;
      vmask    <= 1'b0;
    end else begin
      state <= state_n;
      // a new request in the clearing cycle keeps the bit set
      pba <= (pba & ~clr) | vec_req;
      rd_pipe[0] <= tbl_rden;
      for (int i = 1; i < TBL_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      if (go) begin
        sel <= arb_idx;
        iss <= '0;
        cap <= '0;
      end else if (tbl_rden) begin
        iss <= iss + 3'd1;
      end
      if (cap_en) begin
        cap <= cap + 2'd1;
        unique case (cap)
          MSIX_DW_ADDR_LO: addr_lo  <= tbl_rd_data;
          MSIX_DW_ADDR_HI: addr_hi  <= tbl_rd_data;
          MSIX_DW_DATA:    msg_data <= tbl_rd_data;
          MSIX_DW_VCTRL:   vmask    <= tbl_rd_data[MSIX_VCTRL_MASK_BIT];
        endcase
      end
      if (adv) ptr <= (NUM_VEC == 1) ? '0 : sel + IW'(1);
    end
  end

`ifdef PCILEECH_MSIX_HOLDOFF_EN
  localparam int HW = $clog2(HOLDOFF + 2);
  logic [HW-1:0] hcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
    end else if (hs) begin
      hcnt <= HW'(HOLDOFF);
    end else if (hcnt != '0) begin
      hcnt <= hcnt - HW'(1);
    end
  end

  assign hold_ok = (hcnt == '0);
`else
  // no minimum gap between messages in this build
  assign hold_ok = (HOLDOFF >= 0);
`endif

endmodule

// File: tb/tb_pcileech_msix_msg.sv
// tb_pcileech_msix_msg: directed bench with a cycle-timed reference model
// of the MSI-X message engine and a table-memory responder.
module tb_pcileech_msix_msg;

  localparam int NUM_VEC = 8;
  localparam int TBL_LAT = 2;
  localparam int HOLDOFF = 64;
  localparam int AW      = $clog2(NUM_VEC) + 2;
  localparam int EVAL_T  = 5 + TBL_LAT;

  logic               clk, rst_n, msix_enable, func_mask;
  logic [NUM_VEC-1:0] vec_req, pba;
  logic               tbl_rden, tx_valid, tx_ready, addr_err;
  logic [AW-1:0]      tbl_rd_addr;
  logic [31:0]        tbl_rd_data, tx_data;
  logic [63:0]        tx_addr;

  pcileech_msix_msg #(
    .NUM_VEC(NUM_VEC),
    .TBL_LAT(TBL_LAT),
    .HOLDOFF(HOLDOFF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .msix_enable(msix_enable),
    .func_mask  (func_mask),
    .vec_req    (vec_req),
    .tbl_rden   (tbl_rden),
    .tbl_rd_addr(tbl_rd_addr),
    .tbl_rd_data(tbl_rd_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_addr    (tx_addr),
    .tx_data    (tx_data),
    .pba        (pba),
    .addr_err   (addr_err)
  );

  int n_pass = 0;
  int n_tot  = 0;

  logic [31:0] mem [NUM_VEC][4];

  // reference model state for the current cycle
  bit                 m_busy, m_send;
  int                 m_t, m_sel, m_ptr, m_hold;
  logic [NUM_VEC-1:0] m_pba;
  logic [31:0]        m_ent [4];

  int          cyc = 0;
  logic [31:0] log_q [$];
  int          rden_cnt = 0;
  int          aerr_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic int first_pending(input logic [NUM_VEC-1:0] p,
                                       input int from);
    for (int k = 0; k < NUM_VEC; k++) begin
      int j;
      j = (from + k) % NUM_VEC;
      if (p[j]) return j;
    end
    return -1;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) log_q.push_back(tx_data);
    if (tbl_rden) rden_cnt <= rden_cnt + 1;
    if (addr_err) aerr_cnt <= aerr_cnt + 1;
  end

  // table memory: data for a strobe appears TBL_LAT cycles later
  initial begin
    logic [31:0]   pipe [TBL_LAT];
    logic          r;
    logic [AW-1:0] a;
    tbl_rd_data = 32'hDEAD_BEEF;
    for (int i = 0; i < TBL_LAT; i++) pipe[i] = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      r = tbl_rden;
      a = tbl_rd_addr;
      @(posedge clk);
      #1;
      for (int i = TBL_LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = (r === 1'b1) ? mem[a[AW-1:2]][a[1:0]] : 32'hDEAD_BEEF;
      tbl_rd_data = pipe[TBL_LAT-1];
    end
  end

  // reference model: event timing counted from the selecting IDLE cycle
  initial begin
    logic [NUM_VEC-1:0] clr;
    int                 h0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_busy = 0; m_send = 0; m_t = 0; m_sel = 0;
        m_ptr = 0; m_hold = 0; m_pba = '0;
        for (int d = 0; d < 4; d++) m_ent[d] = '0;
      end else begin
        clr = '0;
        h0  = m_hold;
        if (m_hold > 0) m_hold--;
        if (m_send) begin
          if (tx_ready) begin
            clr[m_sel] = 1'b1;
            m_ptr  = (m_sel + 1) % NUM_VEC;
            m_send = 0;
`ifdef PCILEECH_MSIX_HOLDOFF_EN
            m_hold = HOLDOFF;
`endif
          end
        end else if (m_busy) begin
          if (m_t == EVAL_T) begin
            m_busy = 0;
            if (msix_enable && !func_mask) begin
              if (m_ent[3][0]) begin
                m_ptr = (m_sel + 1) % NUM_VEC;
              end else if (m_ent[0][1:0] != 2'b00) begin
                clr[m_sel] = 1'b1;
                m_ptr = (m_sel + 1) % NUM_VEC;
              end else begin
                m_send = 1;
              end
            end
          end else begin
            m_t++;
          end
        end else if (h0 == 0 && msix_enable && !func_mask && m_pba != '0) begin
          m_sel = first_pending(m_pba, m_ptr);
          for (int d = 0; d < 4; d++) m_ent[d] = mem[m_sel][d];
          m_busy = 1;
          m_t    = 1;
        end
        m_pba = (m_pba & ~clr) | vec_req;
      end
    end
  end

  // compare process
  initial begin
    bit exp_rden, exp_eval, exp_err;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        exp_rden = m_busy && m_t >= 1 && m_t <= 4;
        exp_eval = m_busy && m_t == EVAL_T;
        exp_err  = exp_eval && msix_enable && !func_mask &&
                   !m_ent[3][0] && m_ent[0][1:0] != 2'b00;
        chk("pba", pba, m_pba);
        chk("tx_valid", tx_valid, m_send);
        if (m_send) begin
          chk("tx_addr", tx_addr, {m_ent[1], m_ent[0]});
          chk("tx_data", tx_data, m_ent[2]);
        end
        chk("tbl_rden", tbl_rden, exp_rden);
        if (exp_rden) chk("tbl_rd_addr", tbl_rd_addr, 64'(m_sel * 4 + m_t - 1));
        chk("addr_err", addr_err, exp_err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [NUM_VEC-1:0] v);
    vec_req = v;
    tick();
    vec_req = '0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (m_pba == '0 && !m_busy && !m_send) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk("drain_timeout", ok, 1);
  endtask

  initial begin
    int b, c0, t, n, r0, a0;
    bit seen;
    rst_n = 1'b0; msix_enable = 1'b0; func_mask = 1'b0;
    vec_req = '0; tx_ready = 1'b1;
    for (int v = 0; v < NUM_VEC; v++) begin
      mem[v][0] = 32'hFEE0_0000;
      mem[v][1] = 32'h0;
      mem[v][2] = 32'h4020 + v;
      mem[v][3] = 32'h0;
    end
    mem[7][0] = 32'hFEE0_1000;
    mem[7][1] = 32'h1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pba", pba, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tbl_rden", tbl_rden, 0);
    chk("rst_tx_addr", tx_addr, 0);
    chk("rst_rd_addr", tbl_rd_addr, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    msix_enable = 1'b1;
    tick();

    // round-robin order, with vector 1 re-requested while 5 is sent
    b = log_q.size();
    pulse(8'h62);
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (tx_valid && tx_data == 32'h4025) begin
        seen = 1;
        vec_req[1] = 1'b1;
        break;
      end
    end
    chk("rr_saw_v5", seen, 1);
    @(posedge clk);
    #1;
    vec_req = '0;
    drain();
    chk("rr_count", log_q.size(), b + 4);
    if (log_q.size() == b + 4) begin
      chk("rr_order0", log_q[b],   32'h4021);
      chk("rr_order1", log_q[b+1], 32'h4025);
      chk("rr_order2", log_q[b+2], 32'h4026);
      chk("rr_order3", log_q[b+3], 32'h4021);
    end

    // single vector latency from an idle block
    repeat (HOLDOFF + 4) tick();
    c0 = cyc;
    pulse(8'h08);
    t = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (tx_valid) begin
        t = cyc - c0;
        break;
      end
    end
    chk("lat_cycles", 64'(t), 64'd9);
    chk("lat_addr", tx_addr, 64'h0000_0000_FEE0_0000);
    chk("lat_data", tx_data, 32'h4023);
    tick();
    chk("lat_pba3_clr", pba[3], 0);
    chk("lat_valid_low", tx_valid, 0);
    drain();

    // vector mask keeps the bit pending until unmasked
    b = log_q.size();
    mem[2][3] = 32'h1;
    pulse(8'h04);
    repeat (40) tick();
    chk("vmask_no_send", log_q.size(), b);
    chk("vmask_pba2", pba[2], 1);
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      if (!m_busy && !m_send) begin
        mem[2][3] = 32'h0;
        seen = 1;
        break;
      end
      tick();
    end
    chk("vmask_unmask", seen, 1);
    drain();
    chk("vmask_sent", log_q[$], 32'h4022);
    chk("vmask_pba2_clr", pba[2], 0);

    // function mask blocks fetching entirely
    func_mask = 1'b1;
    r0 = rden_cnt;
    pulse(8'h01);
    repeat (30) tick();
    chk("fmask_no_fetch", rden_cnt - r0, 0);
    chk("fmask_pba0", pba[0], 1);
    func_mask = 1'b0;
    drain();
    chk("fmask_sent", log_q[$], 32'h4020);

    // back-pressure with enable dropping: descriptor held stable
    tx_ready = 1'b0;
    pulse(8'h80);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (tx_valid) begin
        seen = 1;
        break;
      end
    end
    chk("bp_valid", seen, 1);
    @(posedge clk);
    #1;
    msix_enable = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", tx_valid, 1);
      chk("bp_hold_addr", tx_addr, 64'h0000_0001_FEE0_1000);
      chk("bp_hold_data", tx_data, 32'h4027);
    end
    @(posedge clk);
    #1;
    n = log_q.size();
    tx_ready = 1'b1;
    msix_enable = 1'b1;
    tick();
    chk("bp_handshake", log_q.size(), n + 1);
    chk("bp_data", log_q[$], 32'h4027);
    drain();

    // misaligned address is dropped with a single error pulse
    mem[4][0] = 32'hFEE0_0002;
    a0 = aerr_cnt;
    n = log_q.size();
    pulse(8'h10);
    repeat (20) tick();
    chk("drop_err_pulses", aerr_cnt - a0, 1);
    chk("drop_pba4", pba[4], 0);
    chk("drop_no_send", log_q.size(), n);
    drain();
    mem[4][0] = 32'hFEE0_0000;

    // asynchronous reset in the middle of a fetch
    n = log_q.size();
    pulse(8'h20);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (tbl_rden) begin
        seen = 1;
        break;
      end
      tick();
    end
    chk("arst_in_fetch", seen, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_rden", tbl_rden, 0);
    chk("arst_valid", tx_valid, 0);
    chk("arst_err", addr_err, 0);
    chk("arst_pba", pba, 0);
    chk("arst_tx_addr", tx_addr, 0);
    chk("arst_tx_data", tx_data, 0);
    chk("arst_rd_addr", tbl_rd_addr, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) tick();
    chk("arst_no_send", log_q.size(), n);
    chk("arst_pba_idle", pba, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
